// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared constants, state encoding and report codes for the
//               trace line checker.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_TIME     = 4'd1,
        ST_PC       = 4'd2,
        ST_COLON_SP = 4'd3,
        ST_GRF      = 4'd4,
        ST_ADDR     = 4'd5,
        ST_LT       = 4'd6,
        ST_EQ_SP    = 4'd7,
        ST_DATA     = 4'd8,
        ST_DONE     = 4'd9
    } state_e;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam int ERR_PC   = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_GRF  = 2;
    localparam int ERR_TIME = 3;

endpackage
`default_nettype wire

// File: rtl/trace_char_class.sv
`default_nettype none
// ============================================================================
// Module      : trace_char_class
// Description : Classifies one ASCII character as decimal / hex digit and
//               returns its nibble value.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_char_class #(
    parameter bit UPPER_HEX = 1'b0
) (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic is_lower;
    logic is_upper;

    always_comb begin
        is_dec   = (char >= 8'h30) && (char <= 8'h39);
        is_lower = (char >= 8'h61) && (char <= 8'h66);
        is_upper = UPPER_HEX && (char >= 8'h41) && (char <= 8'h46);
        is_hex   = is_dec || is_lower || is_upper;
        nibble   = 4'd0;
        // 'a'/'A' have low nibble 1, so letters map to low nibble + 9
        if (is_dec) begin
            nibble = char[3:0];
        end else if (is_lower || is_upper) begin
            nibble = char[3:0] + 4'd9;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_line_checker.sv
`default_nettype none
// ============================================================================
// Module      : trace_line_checker
// Description : Streaming parser for register/memory write trace lines with
//               PC, address, GRF and time-monotonicity checks.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_line_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_4ffc,
    parameter logic [31:0] ADDR_LIMIT  = 32'h0000_3000,
    parameter bit          UPPER_HEX   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code,
    output logic [31:0] pc_val,
    output logic [31:0] data_val
);

    import trace_pkg::*;

    localparam int TIME_W  = 4 * TIME_DIGITS;
    localparam int GRF_W   = (4 * GRF_DIGITS > 6) ? 4 * GRF_DIGITS : 6;
    localparam int CNT_MAX = (TIME_DIGITS > GRF_DIGITS)
                           ? ((TIME_DIGITS > 8) ? TIME_DIGITS : 8)
                           : ((GRF_DIGITS  > 8) ? GRF_DIGITS  : 8);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TIME_CNT_MAX = CNT_W'(TIME_DIGITS);
    localparam logic [CNT_W-1:0] GRF_CNT_MAX  = CNT_W'(GRF_DIGITS);
    localparam logic [CNT_W-1:0] HEX_CNT      = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic       is_dec;
    logic       is_hex;
    logic [3:0] nibble;

    trace_char_class #(
        .UPPER_HEX (UPPER_HEX)
    ) u_char_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               sp_q,         sp_d;
    logic               is_mem_q,     is_mem_d;
    logic [TIME_W-1:0]  time_q,       time_d;
    logic [31:0]        pc_q,         pc_d;
    logic [GRF_W-1:0]   grf_q,        grf_d;
    logic [31:0]        addr_q,       addr_d;
    logic [31:0]        data_q,       data_d;
    logic [TIME_W-1:0]  last_time_q,  last_time_d;
    logic               last_valid_q, last_valid_d;
    logic [1:0]         format_type_q, format_type_d;
    logic [3:0]         error_code_q,  error_code_d;
    logic [31:0]        pc_val_q,     pc_val_d;
    logic [31:0]        data_val_q,   data_val_d;

    logic               clear_fields;
    logic [TIME_W-1:0]  time_acc;
    logic [GRF_W-1:0]   grf_acc;
    logic [3:0]         err_flags;

    // value*10 + digit never overflows: 10^N < 16^N for the 4N-bit field
    assign time_acc = (time_q * TIME_W'(10)) + TIME_W'(nibble);
    assign grf_acc  = (grf_q  * GRF_W'(10))  + GRF_W'(nibble);

    always_comb begin
        err_flags           = 4'd0;
        err_flags[ERR_PC]   = (pc_q < PC_MIN) || (pc_q > PC_MAX) || (pc_q[1:0] != 2'b00);
        err_flags[ERR_ADDR] = is_mem_q && ((addr_q >= ADDR_LIMIT) || (addr_q[1:0] != 2'b00));
        err_flags[ERR_GRF]  = !is_mem_q && (grf_q > GRF_W'(31));
        err_flags[ERR_TIME] = last_valid_q && (time_q < last_time_q);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sp_d          = sp_q;
        is_mem_d      = is_mem_q;
        time_d        = time_q;
        pc_d          = pc_q;
        grf_d         = grf_q;
        addr_d        = addr_q;
        data_d        = data_q;
        last_time_d   = last_time_q;
        last_valid_d  = last_valid_q;
        format_type_d = FMT_NONE;
        error_code_d  = 4'd0;
        pc_val_d      = pc_val_q;
        data_val_d    = data_val_q;
        clear_fields  = 1'b0;

        if (char == CH_CARET) begin
            state_d      = ST_TIME;
            clear_fields = 1'b1;
        end else begin
            unique case (state_q)
                ST_TIME: begin
                    if (is_dec && (cnt_q < TIME_CNT_MAX)) begin
                        cnt_d  = cnt_q + CNT_ONE;
                        time_d = time_acc;
                    end else if ((char == CH_AT) && (cnt_q != '0)) begin
                        state_d = ST_PC;
                        cnt_d   = '0;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                ST_PC: begin
                    if (is_hex && (cnt_q < HEX_CNT)) begin
                        cnt_d = cnt_q + CNT_ONE;
                        pc_d  = {pc_q[27:0], nibble};
                    end else if ((char == CH_COLON) && (cnt_q == HEX_CNT)) begin
                        state_d = ST_COLON_SP;
                        cnt_d   = '0;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                ST_COLON_SP: begin
                    if (char == CH_SPACE) begin
                        state_d = ST_COLON_SP;
                    end else if (char == CH_DOLLAR) begin
                        state_d  = ST_GRF;
                        is_mem_d = 1'b0;
                    end else if (char == CH_STAR) begin
                        state_d  = ST_ADDR;
                        is_mem_d = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                // sp_q marks that trailing spaces began; digits are no longer legal
                ST_GRF: begin
                    if (is_dec && !sp_q && (cnt_q < GRF_CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_ONE;
                        grf_d = grf_acc;
                    end else if ((char == CH_SPACE) && (cnt_q != '0)) begin
                        sp_d = 1'b1;
                    end else if ((char == CH_LT) && (cnt_q != '0)) begin
                        state_d = ST_LT;
                        cnt_d   = '0;
                        sp_d    = 1'b0;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (is_hex && !sp_q && (cnt_q < HEX_CNT)) begin
                        cnt_d  = cnt_q + CNT_ONE;
                        addr_d = {addr_q[27:0], nibble};
                    end else if ((char == CH_SPACE) && (cnt_q == HEX_CNT)) begin
                        sp_d = 1'b1;
                    end else if ((char == CH_LT) && (cnt_q == HEX_CNT)) begin
                        state_d = ST_LT;
                        cnt_d   = '0;
                        sp_d    = 1'b0;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                ST_LT: begin
                    if (char == CH_EQ) begin
                        state_d = ST_EQ_SP;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                ST_EQ_SP: begin
                    if (char == CH_SPACE) begin
                        state_d = ST_EQ_SP;
                    end else if (is_hex) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_ONE;
                        data_d  = {data_q[27:0], nibble};
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (is_hex && (cnt_q < HEX_CNT)) begin
                        cnt_d  = cnt_q + CNT_ONE;
                        data_d = {data_q[27:0], nibble};
                    end else if ((char == CH_HASH) && (cnt_q == HEX_CNT)) begin
                        state_d       = ST_DONE;
                        format_type_d = is_mem_q ? FMT_MEM : FMT_REG;
                        error_code_d  = err_flags;
                        last_time_d   = time_q;
                        last_valid_d  = 1'b1;
                        pc_val_d      = pc_q;
                        data_val_d    = data_q;
                    end else begin
                        state_d      = ST_IDLE;
                        clear_fields = 1'b1;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    clear_fields = 1'b1;
                end
            endcase
        end

        if (clear_fields) begin
            cnt_d    = '0;
            sp_d     = 1'b0;
            is_mem_d = 1'b0;
            time_d   = '0;
            pc_d     = '0;
            grf_d    = '0;
            addr_d   = '0;
            data_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sp_q          <= 1'b0;
            is_mem_q      <= 1'b0;
            time_q        <= '0;
            pc_q          <= '0;
            grf_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            last_time_q   <= '0;
            last_valid_q  <= 1'b0;
            format_type_q <= FMT_NONE;
            error_code_q  <= 4'd0;
            pc_val_q      <= '0;
            data_val_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sp_q          <= sp_d;
            is_mem_q      <= is_mem_d;
            time_q        <= time_d;
            pc_q          <= pc_d;
            grf_q         <= grf_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            last_time_q   <= last_time_d;
            last_valid_q  <= last_valid_d;
            format_type_q <= format_type_d;
            error_code_q  <= error_code_d;
            pc_val_q      <= pc_val_d;
            data_val_q    <= data_val_d;
        end
    end

    assign format_type = format_type_q;
    assign error_code  = error_code_q;
    assign pc_val      = pc_val_q;
    assign data_val    = data_val_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_line_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_line_checker
// Description : Self-checking bench; two checkers (lowercase-only and
//               uppercase-accepting hex) share one character stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_line_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ch;
    logic [1:0]  fmt_o  [2];
    logic [3:0]  err_o  [2];
    logic [31:0] pc_o   [2];
    logic [31:0] data_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_line_checker dut_lc (
        .clk (clk), .reset (reset), .char (ch),
        .format_type (fmt_o[0]), .error_code (err_o[0]),
        .pc_val (pc_o[0]), .data_val (data_o[0])
    );

    trace_line_checker #(.UPPER_HEX (1'b1)) dut_uc (
        .clk (clk), .reset (reset), .char (ch),
        .format_type (fmt_o[1]), .error_code (err_o[1]),
        .pc_val (pc_o[1]), .data_val (data_o[1])
    );

    // ---------------- reference model (whole-line grammar) ----------------
    string       lbuf;
    bit          active;
    bit          lv       [2];
    longint      lt       [2];
    int          exp_cnt  [2];
    logic [1:0]  exp_fmt  [2];
    logic [3:0]  exp_err  [2];
    logic [31:0] exp_pc   [2];
    logic [31:0] exp_data [2];
    int          rep_cnt  [2];
    int          late     [2];
    logic [1:0]  rep_fmt  [2];
    logic [3:0]  rep_err  [2];

    function automatic bit isdec(byte c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic bit ishex(byte c, bit up);
        return isdec(c) || ((c >= "a") && (c <= "f")) || (up && (c >= "A") && (c <= "F"));
    endfunction

    function automatic logic [3:0] hexval(byte c);
        if (isdec(c)) return 4'(c - 48);
        if (c >= "a") return 4'(c - 87);
        return 4'(c - 55);
    endfunction

    function automatic bit at_is(string s, int i, byte c);
        return (i < s.len()) && (s[i] == c);
    endfunction

    function automatic bit parse(input string s, input bit up, output bit mem,
                                 output longint t, output logic [31:0] pc,
                                 output longint grf, output logic [31:0] addr,
                                 output logic [31:0] data);
        int i;
        int nd;
        int n;
        mem = 0; t = 0; pc = 0; grf = 0; addr = 0; data = 0;
        n = s.len();
        i = 1;
        nd = 0;
        while (i < n && isdec(s[i])) begin t = t * 10 + hexval(s[i]); nd++; i++; end
        if (nd < 1 || nd > 4 || !at_is(s, i, "@")) return 0;
        i++; nd = 0;
        while (i < n && ishex(s[i], up)) begin pc = {pc[27:0], hexval(s[i])}; nd++; i++; end
        if (nd != 8 || !at_is(s, i, ":")) return 0;
        i++;
        while (at_is(s, i, " ")) i++;
        if (at_is(s, i, "$")) begin
            i++; nd = 0;
            while (i < n && isdec(s[i])) begin grf = grf * 10 + hexval(s[i]); nd++; i++; end
            if (nd < 1 || nd > 4) return 0;
        end else if (at_is(s, i, "*")) begin
            mem = 1; i++; nd = 0;
            while (i < n && ishex(s[i], up)) begin addr = {addr[27:0], hexval(s[i])}; nd++; i++; end
            if (nd != 8) return 0;
        end else begin
            return 0;
        end
        while (at_is(s, i, " ")) i++;
        if (!at_is(s, i, "<") || !at_is(s, i + 1, "=")) return 0;
        i += 2;
        while (at_is(s, i, " ")) i++;
        nd = 0;
        while (i < n && ishex(s[i], up)) begin data = {data[27:0], hexval(s[i])}; nd++; i++; end
        if (nd != 8 || !at_is(s, i, "#")) return 0;
        return i == n - 1;
    endfunction

    task automatic mdl_char(byte c);
        bit mem; longint t; longint grf; logic [31:0] pc, addr, data;
        if (c == "^") begin
            lbuf = "^"; active = 1;
        end else if (active) begin
            lbuf = $sformatf("%s%c", lbuf, c);
            if (c == "#") begin
                for (int k = 0; k < 2; k++) begin
                    if (parse(lbuf, k == 1, mem, t, pc, grf, addr, data)) begin
                        exp_cnt[k]++;
                        exp_fmt[k]    = mem ? 2'd2 : 2'd1;
                        exp_err[k][0] = (pc < 32'h3000) || (pc > 32'h4ffc) || (pc[1:0] != 0);
                        exp_err[k][1] = mem && ((addr >= 32'h3000) || (addr[1:0] != 0));
                        exp_err[k][2] = !mem && (grf > 31);
                        exp_err[k][3] = lv[k] && (t < lt[k]);
                        lt[k] = t; lv[k] = 1;
                        exp_pc[k] = pc; exp_data[k] = data;
                    end
                end
                active = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ch = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        active = 0;
        for (int k = 0; k < 2; k++) begin
            lv[k] = 0; lt[k] = 0; exp_pc[k] = 0; exp_data[k] = 0;
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            rep_cnt[k] = 0; late[k] = 0; exp_cnt[k] = 0;
            rep_fmt[k] = 0; rep_err[k] = 0; exp_fmt[k] = 0; exp_err[k] = 0;
        end
    endtask

    task automatic send_char(byte c);
        @(negedge clk);
        ch = c;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (fmt_o[k] != 2'd0) begin
                rep_cnt[k]++; rep_fmt[k] = fmt_o[k]; rep_err[k] = err_o[k];
                if (c != "#") late[k]++;
            end
        end
        mdl_char(c);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (fmt_o[0] !== 2'd0) begin errors++; $display("FAIL reset_fmt got %0d want 0", fmt_o[0]); end
        checks++; if (err_o[0] !== 4'd0) begin errors++; $display("FAIL reset_err got %b want 0000", err_o[0]); end
        checks++; if (pc_o[0] !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_o[0]); end
        checks++; if (data_o[0] !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_o[0]); end
    endtask

    task automatic test_reg_line();
        do_reset(); clear_obs();
        send_str("^10@00003000: $1 <= 0000000a#");
        checks++; if (fmt_o[0] !== 2'd1) begin errors++; $display("FAIL reg_fmt got %0d want 1", fmt_o[0]); end
        checks++; if (err_o[0] !== 4'd0) begin errors++; $display("FAIL reg_err got %b want 0000", err_o[0]); end
        checks++; if (pc_o[0] !== 32'h3000) begin errors++; $display("FAIL reg_pc got %h want 00003000", pc_o[0]); end
        checks++; if (data_o[0] !== 32'ha) begin errors++; $display("FAIL reg_data got %h want 0000000a", data_o[0]); end
        send_char(8'h0A);
        checks++; if (fmt_o[0] !== 2'd0) begin errors++; $display("FAIL reg_fmt_drop got %0d want 0", fmt_o[0]); end
        checks++; if (data_o[0] !== 32'ha) begin errors++; $display("FAIL reg_data_hold got %h want 0000000a", data_o[0]); end
    endtask

    task automatic test_mem_line();
        send_str("^11@00003004: *00000010 <= deadbeef#");
        checks++; if (fmt_o[0] !== 2'd2) begin errors++; $display("FAIL mem_fmt got %0d want 2", fmt_o[0]); end
        checks++; if (err_o[0] !== 4'd0) begin errors++; $display("FAIL mem_err got %b want 0000", err_o[0]); end
        checks++; if (data_o[0] !== 32'hdeadbeef) begin errors++; $display("FAIL mem_data got %h want deadbeef", data_o[0]); end
    endtask

    task automatic test_errors();
        do_reset();
        send_str("^20@00002ffe: $40 <= 00000001#");
        checks++; if (fmt_o[0] !== 2'd1) begin errors++; $display("FAIL err_reg_fmt got %0d want 1", fmt_o[0]); end
        checks++; if (err_o[0] !== 4'b0101) begin errors++; $display("FAIL err_pc_grf got %b want 0101", err_o[0]); end
        send_str("^21@00003000: *00003000 <= 00000000#");
        checks++; if (err_o[0] !== 4'b0010) begin errors++; $display("FAIL err_addr got %b want 0010", err_o[0]); end
    endtask

    task automatic test_monotonic();
        do_reset();
        send_str("^30@00003000: $1 <= 00000001#");
        send_str("^7@00003000: $1 <= 00000001#");
        checks++; if (err_o[0] !== 4'b1000) begin errors++; $display("FAIL time_back got %b want 1000", err_o[0]); end
        send_str("^30@00003000: $1 <= 00000001#");
        do_reset();
        send_str("^7@00003000: $1 <= 00000001#");
        checks++; if (err_o[0] !== 4'b0000) begin errors++; $display("FAIL time_after_reset got %b want 0000", err_o[0]); end
    endtask

    task automatic test_restart_and_illegal();
        do_reset(); clear_obs();
        send_str("^12@0000^1@00003000: $0 <= 00000000#");
        checks++; if (rep_cnt[0] !== 1) begin errors++; $display("FAIL restart_count got %0d want 1", rep_cnt[0]); end
        checks++; if (rep_fmt[0] !== 2'd1) begin errors++; $display("FAIL restart_fmt got %0d want 1", rep_fmt[0]); end
        clear_obs();
        send_str("^12345@00003000: $0 <= 00000000#");
        send_str("^1@00003000: $1 2 <= 00000001#");
        send_str("^1@0000300: $1 <= 00000001#");
        checks++; if (rep_cnt[0] !== 0) begin errors++; $display("FAIL illegal_count got %0d want 0", rep_cnt[0]); end
        clear_obs();
        send_str("^1@00003000: $0 <= DEADBEEF#");
        checks++; if (rep_cnt[0] !== 0) begin errors++; $display("FAIL upper_lc got %0d reports want 0", rep_cnt[0]); end
        checks++; if (rep_cnt[1] !== 1) begin errors++; $display("FAIL upper_uc got %0d reports want 1", rep_cnt[1]); end
        checks++; if (data_o[1] !== 32'hdeadbeef) begin errors++; $display("FAIL upper_data got %h want deadbeef", data_o[1]); end
    endtask

    task automatic test_reset_midline();
        do_reset(); clear_obs();
        send_str("^1@000030");
        do_reset();
        send_str("00: $1 <= 00000001#");
        checks++; if (rep_cnt[0] !== 0) begin errors++; $display("FAIL midreset_count got %0d want 0", rep_cnt[0]); end
        send_str("^2@00003000: $1 <= 00000001#");
        checks++; if (fmt_o[0] !== 2'd1) begin errors++; $display("FAIL midreset_next got %0d want 1", fmt_o[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset(); clear_obs();
        send_str("^1@00003000: $2 <= 00000003#^2@00003008: *00000004 <= 00000005#");
        checks++; if (rep_cnt[0] !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", rep_cnt[0]); end
        checks++; if (pc_o[0] !== 32'h3008) begin errors++; $display("FAIL b2b_pc got %h want 00003008", pc_o[0]); end
        checks++; if (data_o[0] !== 32'h5) begin errors++; $display("FAIL b2b_data got %h want 00000005", data_o[0]); end
    endtask

    function automatic string spaces(int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    function automatic logic [31:0] pick_addr(logic [31:0] base);
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return base + 32'($urandom_range(0, 2047)) * 4;
            2: return base - 32'($urandom_range(0, 2047)) * 4 + 32'($urandom_range(0, 3));
            default: return base + 32'($urandom_range(0, 8)) - 4;
        endcase
    endfunction

    function automatic string gen_line();
        string ts = "", pcs, body, ds, s;
        int nt;
        byte c;
        nt = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
        for (int i = 0; i < nt; i++) ts = $sformatf("%s%0d", ts, $urandom_range(0, 9));
        pcs = $sformatf("%08h", pick_addr(($urandom_range(0, 1) == 0) ? 32'h3000 : 32'h4ffc));
        if ($urandom_range(0, 7) == 0) pcs = pcs.toupper();
        if ($urandom_range(0, 1) == 0) begin
            if ($urandom_range(0, 15) == 0) body = $sformatf("$%05d", $urandom_range(0, 99999));
            else body = $sformatf("$%0d", ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 40));
        end else begin
            body = $sformatf("*%08h", pick_addr(32'h3000));
        end
        ds = $sformatf("%08h", $urandom);
        if ($urandom_range(0, 7) == 0) ds = ds.toupper();
        s = $sformatf("^%s@%s:%s%s%s<=%s%s#", ts, pcs, spaces($urandom_range(0, 2)), body,
                      spaces($urandom_range(0, 2)), spaces($urandom_range(0, 2)), ds);
        if ($urandom_range(0, 7) == 0) begin
            c = byte'($urandom_range(32, 126));
            s.putc($urandom_range(1, s.len() - 1), c);
        end
        if ($urandom_range(0, 15) == 0) s = s.substr(0, $urandom_range(1, s.len() - 2));
        return s;
    endfunction

    task automatic test_random();
        string s;
        int cut;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            clear_obs();
            s = gen_line();
            if ($urandom_range(0, 24) == 0) begin
                cut = $urandom_range(1, s.len() - 1);
                send_str(s.substr(0, cut - 1));
                do_reset();
                send_str(s.substr(cut, s.len() - 1));
            end else begin
                send_str(s);
            end
            if ($urandom_range(0, 2) == 0) send_char(8'h0A);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rep_cnt[k] !== exp_cnt[k]) begin
                    errors++; $display("FAIL rnd_count[%0d] got %0d want %0d line %s", k, rep_cnt[k], exp_cnt[k], s);
                end
                checks++;
                if (late[k] !== 0) begin
                    errors++; $display("FAIL rnd_timing[%0d] got %0d off-cycle reports want 0", k, late[k]);
                end
                if (exp_cnt[k] > 0 && rep_cnt[k] > 0) begin
                    checks++;
                    if (rep_fmt[k] !== exp_fmt[k] || rep_err[k] !== exp_err[k]) begin
                        errors++; $display("FAIL rnd_report[%0d] got fmt %0d err %b want fmt %0d err %b line %s",
                                           k, rep_fmt[k], rep_err[k], exp_fmt[k], exp_err[k], s);
                    end
                end
                checks++;
                if (pc_o[k] !== exp_pc[k] || data_o[k] !== exp_data[k]) begin
                    errors++; $display("FAIL rnd_vals[%0d] got pc %h data %h want pc %h data %h",
                                       k, pc_o[k], data_o[k], exp_pc[k], exp_data[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ch    = 8'h00;
        lbuf  = "";
        active = 0;
        clear_obs();
        test_reset();
        test_reg_line();
        test_mem_line();
        test_errors();
        test_monotonic();
        test_restart_and_illegal();
        test_reset_midline();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_line_checker.md
# trace_line_checker

Streaming checker for CPU trace lines, fed one ASCII character per clock from the simulation log path. It recognises register-write lines (`^<time>@<pc>: $<grf> <= <data>#`) and memory-write lines (`^<time>@<pc>: *<addr> <= <data>#`), and reports the line type one cycle after the terminating `#`. It also reports semantic error flags and the captured PC and data values. Field widths, the legal PC window and the address limit are parameters, and a `^` anywhere restarts parsing.

## Interface
- `TIME_DIGITS`, 4: max decimal digits in `<time>` (min 1)
- `GRF_DIGITS`, 4: max decimal digits in `<grf>` (min 1)
- `PC_MIN`, 32'h0000_3000: lowest legal PC
- `PC_MAX`, 32'h0000_4ffc: highest legal PC
- `ADDR_LIMIT`, 32'h0000_3000: memory addresses must be below this
- `UPPER_HEX`, 0: 1 also accepts `A`-`F` as hex digits
- `clk` input 1: clock
- `reset` input 1: synchronous, active-high
- `char` input 8: ASCII character, sampled every rising edge
- `format_type` output 2: 0 none, 1 register line, 2 memory line
- `error_code` output 4: bit0 PC error, bit1 addr error, bit2 GRF error, bit3 time non-monotonic
- `pc_val` output 32: PC of the last well-formed line
- `data_val` output 32: data of the last well-formed line

## Operation
- States: IDLE, TIME, PC, COLON_SP, GRF, ADDR, LT, EQ_SP, DATA, DONE.
- IDLE: `^` goes to TIME.
- TIME:
  - 1..TIME_DIGITS decimal digits, then `@`.
  - Value accumulates as value*10 + digit, 4*TIME_DIGITS bits wide.
- PC: exactly 8 hex digits, then `:`.
- COLON_SP: zero or more spaces, then `$` (to GRF) or `*` (to ADDR).
- GRF:
  - 1..GRF_DIGITS decimal digits, then zero or more spaces, then `<`.
  - A digit after a space is illegal.
- ADDR: exactly 8 hex digits, then zero or more spaces, then `<`.
- LT: the next char must be `=`.
- EQ_SP: zero or more spaces, then exactly 8 hex digits, then `#`, which goes to DONE.
- Any character not allowed by the current state goes to IDLE and clears all counters.
- `^` in any state (including DONE) restarts at TIME with cleared counters and accumulators.
- DONE lasts one cycle; the next char is handled exactly as in IDLE.
- Hex letters are lowercase only unless UPPER_HEX=1. Digit counters saturate-check before increment; an over-long field is illegal.
- Error flags, evaluated at `#`:
  - bit0: pc < PC_MIN, pc > PC_MAX, or pc[1:0] != 0.
  - bit1: memory line only; addr >= ADDR_LIMIT or addr[1:0] != 0.
  - bit2: register line only; grf > 31.
  - bit3: a previous well-formed line exists since reset and time < last_time.
- On entering DONE:
  - last_time <= time and the last-time-valid flag is set, regardless of error flags.
  - pc_val and data_val are loaded.

## Timing
- Reset values: state IDLE, all counters and accumulators 0, last-time-valid flag 0, last_time 0, `format_type` 0, `error_code` 0, `pc_val` 0, `data_val` 0.
- `format_type` and `error_code` are nonzero only while in DONE, i.e. the cycle after the edge that sampled `#`. They are 0 in every other state.
- `pc_val` and `data_val` update on the same edge that enters DONE and hold until the next DONE or reset.
- Latency: one cycle from sampling `#` to the report.
- Throughput: back-to-back lines allowed; a `^` sampled in DONE starts the next line with no gap.
- Reset mid-line discards the partial line and the monotonic history.
- Reset has priority over `char`.

## Structure
- Package `trace_pkg`:
  - ASCII constants (`^ @ : $ * < = # space`).
  - State enum.
  - format_type codes FMT_NONE=0, FMT_REG=1, FMT_MEM=2.
  - error bit indices ERR_PC=0, ERR_ADDR=1, ERR_GRF=2, ERR_TIME=3.
- One sub-module, `trace_char_class`: combinational. Input `char` and UPPER_HEX; outputs is_dec, is_hex, 4-bit nibble value. Instantiated once.

## Test plan
- `^10@00003000: $1 <= 0000000a#` -> next cycle format_type=1, error_code=0, pc_val=0x3000, data_val=0xa; following cycle format_type=0.
- `^11@00003004: *00000010 <= deadbeef#` -> format_type=2, error_code=0, data_val=0xdeadbeef.
- `^20@00002ffe: $40 <= 00000001#` -> format_type=1, error_code=4'b0101. `^21@00003000: *00003000 <= 00000000#` -> error_code=4'b0010.
- `^30@00003000: $1 <= 00000001#` then `^7@00003000: $1 <= 00000001#` -> second report has error_code=4'b1000. Reset between the two lines -> error_code=0.
- `^12@0000^1@00003000: $0 <= 00000000#` -> exactly one report, format_type=1. `^12345@00003000: $0 <= 00000000#` with TIME_DIGITS=4 -> format_type stays 0. `...DEADBEEF#` with UPPER_HEX=0 -> 0; with UPPER_HEX=1 -> reported.
- Reset asserted after `^1@000030`, then the rest of the line -> no report. The next full line reports normally.
